// File: rtl/usb4_lane_pkg.sv
// Shared definitions for the two-lane receive path: lane byte width,
// default FIFO sizing / skew tolerance, and the merger FSM state encoding.
package usb4_lane_pkg;

  localparam int LANE_W         = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_SKEW_MAX   = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FILL     = 2'd1,
    ST_MERGE_L0 = 2'd2,
    ST_MERGE_L1 = 2'd3
  } merge_state_t;

endpackage

// File: rtl/lane_rx_fifo.sv
// Per-lane deskew FIFO. Head byte is visible on data whenever the FIFO is
// non-empty. flush empties it on the next edge and wins over push/pop.
// Push and pop together on a full FIFO is accepted (count unchanged); a push
// to a full FIFO without a pop is dropped (the parent flags that). A pop of
// an empty FIFO is ignored. DEPTH must be a power of two, at least 2, so
// the pointers wrap naturally.
module lane_rx_fifo
  import usb4_lane_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [LANE_W-1:0]        din,
  output logic [LANE_W-1:0]        data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

  logic [LANE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign data    = mem[rd_ptr];

  // Storage write; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lane_merger.sv
// Receive-side lane merger. In data mode the two lane byte streams are
// deskewed in per-lane FIFOs and re-interleaved (lane 0 byte, then lane 1
// byte) onto merged_out. In ordered-set mode both lanes are forwarded as a
// registered pair.
//
// Handshake: every lane input and every output is valid-only (no ready).
// A byte is taken on any rising edge where its *_vld is high; a byte is
// delivered on any edge where merged_vld / os_vld is high. There is no
// back-pressure; a lane FIFO that cannot accept a byte drops it and raises
// the sticky skew_err.
//
// Optional feature: define LANE_MERGER_SKEW_CHECK_EN to build the skew
// timeout counter (SKEW_MAX FILL cycles with only one lane holding data
// flushes both FIFOs and raises skew_err).
module lane_merger
  import usb4_lane_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int SKEW_MAX   = DEF_SKEW_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_r,
  input  logic              data_os_i,
  input  logic [LANE_W-1:0] lane_0_rx_in,
  input  logic              lane_0_rx_vld,
  input  logic [LANE_W-1:0] lane_1_rx_in,
  input  logic              lane_1_rx_vld,
  output logic [LANE_W-1:0] merged_out,
  output logic              merged_vld,
  output logic [LANE_W-1:0] lane_0_os_out,
  output logic [LANE_W-1:0] lane_1_os_out,
  output logic              os_vld,
  output logic              merge_busy,
  output logic              skew_err
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0] LVL_ONE = 1;

  merge_state_t state_q;
  merge_state_t state_d;

  logic              active;
  logic              fifo_flush;
  logic              skew_timeout;
  logic              os_pair;
  logic              push_0, push_1;
  logic              pop_0, pop_1;
  logic [LANE_W-1:0] data_0, data_1;
  logic              empty_0, empty_1;
  logic              full_0, full_1;
  logic [LVL_W-1:0]  level_0, level_1;
  logic              ne_after_0, ne_after_1;
  logic              overflow;

  assign active     = enable_r & data_os_i;
  assign fifo_flush = ~active | skew_timeout;
  assign os_pair    = ~data_os_i & lane_0_rx_vld & lane_1_rx_vld;
  assign push_0     = active & lane_0_rx_vld;
  assign push_1     = active & lane_1_rx_vld;
  assign pop_0      = active & (state_q == ST_MERGE_L0);
  assign pop_1      = active & (state_q == ST_MERGE_L1);

  // Occupancy of each FIFO once this cycle's push/pop has been applied.
  assign ne_after_0 = push_0 | (pop_0 ? (level_0 > LVL_ONE) : ~empty_0);
  assign ne_after_1 = push_1 | (pop_1 ? (level_1 > LVL_ONE) : ~empty_1);

  assign overflow = (push_0 & full_0 & ~pop_0) | (push_1 & full_1 & ~pop_1);

  lane_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_0 (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (push_0),
    .pop   (pop_0),
    .din   (lane_0_rx_in),
    .data  (data_0),
    .empty (empty_0),
    .full  (full_0),
    .level (level_0)
  );

  lane_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_1 (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (push_1),
    .pop   (pop_1),
    .din   (lane_1_rx_in),
    .data  (data_1),
    .empty (empty_1),
    .full  (full_1),
    .level (level_1)
  );

`ifdef LANE_MERGER_SKEW_CHECK_EN
  localparam int SKW = $clog2(SKEW_MAX + 1);
  localparam logic [SKW-1:0] SKEW_LAST = SKW'(SKEW_MAX - 1);
  localparam logic [SKW-1:0] SKEW_ONE  = 1;

  logic [SKW-1:0] skew_cnt;
  logic           one_lane;

  assign one_lane     = active & (state_q == ST_FILL) & (empty_0 ^ empty_1);
  assign skew_timeout = one_lane & (skew_cnt == SKEW_LAST);

  // Count consecutive FILL cycles where only one lane holds data.
  always_ff @(posedge clk) begin
    if (rst || !one_lane || skew_timeout) begin
      skew_cnt <= '0;
    end else begin
      skew_cnt <= skew_cnt + SKEW_ONE;
    end
  end
`else
  logic unused_skew_max;
  assign unused_skew_max = (SKEW_MAX == 0);
  assign skew_timeout    = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: wait for both lanes, then alternate lane 0 / lane 1 pops.
  always_comb begin
    state_d = state_q;
    if (!active) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_FILL;
        ST_FILL:     if (!empty_0 && !empty_1) state_d = ST_MERGE_L0;
        ST_MERGE_L0: state_d = ST_MERGE_L1;
        ST_MERGE_L1: state_d = (ne_after_0 && ne_after_1) ? ST_MERGE_L0 : ST_FILL;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Registered outputs; disable behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || !enable_r) begin
      merged_out    <= '0;
      merged_vld    <= 1'b0;
      lane_0_os_out <= '0;
      lane_1_os_out <= '0;
      os_vld        <= 1'b0;
      merge_busy    <= 1'b0;
      skew_err      <= 1'b0;
    end else begin
      os_vld <= os_pair;
      if (os_pair) begin
        lane_0_os_out <= lane_0_rx_in;
        lane_1_os_out <= lane_1_rx_in;
      end
      merged_vld <= pop_0 | pop_1;
      if (pop_0) begin
        merged_out <= data_0;
      end else if (pop_1) begin
        merged_out <= data_1;
      end
      merge_busy <= (state_d == ST_MERGE_L0) || (state_d == ST_MERGE_L1);
      if (overflow || skew_timeout) begin
        skew_err <= 1'b1;
      end
    end
  end

endmodule
